// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: per-stage load enables and bubble inserts from
// stall/flush requests, debug halt/step, stall watchdog; optional perf counters (PIPE_PERF_CNT_EN).
//
// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | normal operation, stall/flush arbitration drives the stages
// HALTED | debug halt, every pipeline register holds, counters frozen
// STEP   | single advance cycle taken from HALTED, then back to HALTED
module pipeline_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int TO_W       = 16,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] flush_req,
    input  logic                  halt_req,
    input  logic                  step,
    input  logic                  resume,
    input  logic [TO_W-1:0]       timeout_limit,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_bubble,
    output logic                  halted,
    output logic                  timeout,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NUM_STAGES-1:0] stall_ge;
    logic [NUM_STAGES-1:0] flush_ge;
    logic                  flush_hit;
    logic                  stall_hit;
    logic                  active;
    logic                  stall_eff;
    logic                  flush_eff;
    logic [TO_W-1:0]       to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (halt_req) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_nxt = RUN;
                end else if (step) begin
                    state_nxt = STEP;
                end
            end
            STEP: begin
                state_nxt = resume ? RUN : HALTED;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign halted = (state == HALTED);

    // stall_ge[i]: some stage at index >= i is stalled (same idea for flush_ge)
    always_comb begin
        stall_ge = '0;
        flush_ge = '0;
        stall_ge[NUM_STAGES-1] = stall_req[NUM_STAGES-1];
        flush_ge[NUM_STAGES-1] = flush_req[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            stall_ge[i] = stall_req[i] | stall_ge[i+1];
            flush_ge[i] = flush_req[i] | flush_ge[i+1];
        end
    end

    // A flush wins only if it sits above every stalled stage.
    assign flush_hit = |(flush_req & ~stall_ge);
    assign stall_hit = stall_ge[0] & ~flush_hit;
    assign active    = !rst && (state != HALTED);
    assign stall_eff = active && stall_hit;
    assign flush_eff = active && flush_hit;

    always_comb begin
        stage_en     = '1;
        stage_bubble = '0;
        if (rst) begin
            stage_en     = '1;
            stage_bubble = '1;
        end else if (state == HALTED) begin
            stage_en     = '0;
            stage_bubble = '0;
        end else if (flush_hit) begin
            stage_en        = '1;
            stage_bubble    = flush_ge;
            stage_bubble[0] = 1'b0;
        end else if (stall_hit) begin
            stage_en = ~stall_ge;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stage_bubble[i] = ~stall_ge[i] & stall_ge[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (active) begin
            if ((timeout_limit != '0) && (to_cnt == timeout_limit)) begin
                timeout <= 1'b1;
            end
            if (stall_eff) begin
                if (to_cnt != '1) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (active) begin
            if (cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (stall_eff && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_eff && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

    localparam int N     = 5;
    localparam int TO_W  = 16;
    localparam int CNT_W = 32;
    localparam longint CMAX  = (longint'(1) << CNT_W) - 1;
    localparam int     TOMAX = (1 << TO_W) - 1;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    stall_req, flush_req;
    logic            halt_req, step, resume;
    logic [TO_W-1:0] timeout_limit;
    logic [N-1:0]    stage_en, stage_bubble;
    logic            halted, timeout;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

    pipeline_ctrl #(.NUM_STAGES(N), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
        .halt_req(halt_req), .step(step), .resume(resume),
        .timeout_limit(timeout_limit), .stage_en(stage_en),
        .stage_bubble(stage_bubble), .halted(halted), .timeout(timeout),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: mode 0 = running, 1 = halted, 2 = single step
    bit     m_ok = 1'b0;
    int     m_mode;
    int     m_to;
    bit     m_timeout;
    longint m_cyc, m_stl, m_fl;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int hi_idx(input logic [N-1:0] v);
        int r = -1;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic model_outputs(output int e, output int b, output bit st_eff, output bit fl_eff);
        int s, f, all;
        s = hi_idx(stall_req);
        f = hi_idx(flush_req);
        all = (1 << N) - 1;
        st_eff = 1'b0;
        fl_eff = 1'b0;
        if (rst) begin
            e = all; b = all;
        end else if (m_mode == 1) begin
            e = 0; b = 0;
        end else if (f >= 0 && (s < 0 || f > s)) begin
            fl_eff = 1'b1;
            e = all;
            b = ((1 << (f + 1)) - 1) & ~1;
        end else if (s >= 0) begin
            st_eff = 1'b1;
            e = all & ~((1 << (s + 1)) - 1);
            b = (s + 1 < N) ? (1 << (s + 1)) : 0;
        end else begin
            e = all; b = 0;
        end
    endtask

    task automatic apply(input bit r, input logic [N-1:0] sr, input logic [N-1:0] fr,
                         input bit hr, input bit st, input bit rs, input logic [TO_W-1:0] lim);
        int e, b;
        bit se, fe;
        @(negedge clk);
        rst = r; stall_req = sr; flush_req = fr;
        halt_req = hr; step = st; resume = rs; timeout_limit = lim;
        #1;
        model_outputs(e, b, se, fe);
        check_val("stage_en", 64'(stage_en), 64'(e));
        check_val("stage_bubble", 64'(stage_bubble), 64'(b));
        if (m_ok) begin
            check_val("halted", 64'(halted), 64'(m_mode == 1));
            check_val("timeout", 64'(timeout), 64'(m_timeout));
            check_val("cycle_cnt", 64'(cycle_cnt), PERF ? 64'(m_cyc) : 64'd0);
            check_val("stall_cnt", 64'(stall_cnt), PERF ? 64'(m_stl) : 64'd0);
            check_val("flush_cnt", 64'(flush_cnt), PERF ? 64'(m_fl) : 64'd0);
        end
    endtask

    task automatic tick();
        int e, b;
        bit se, fe;
        @(posedge clk);
        model_outputs(e, b, se, fe);
        if (rst) begin
            m_ok = 1'b1; m_mode = 0; m_to = 0; m_timeout = 1'b0;
            m_cyc = 0; m_stl = 0; m_fl = 0;
        end else if (m_ok) begin
            if (m_mode != 1) begin
                if (m_cyc < CMAX) m_cyc++;
                if (se && m_stl < CMAX) m_stl++;
                if (fe && m_fl < CMAX) m_fl++;
                if (timeout_limit != 0 && m_to == int'(timeout_limit)) m_timeout = 1'b1;
                m_to = se ? ((m_to < TOMAX) ? m_to + 1 : TOMAX) : 0;
            end
            case (m_mode)
                0: if (halt_req) m_mode = 1;
                1: if (resume) m_mode = 0; else if (step) m_mode = 2;
                default: m_mode = resume ? 0 : 1;
            endcase
        end
    endtask

    initial begin
        logic [TO_W-1:0] lim;
        logic [N-1:0]    sr, fr;

        rst = 1'b1; stall_req = '0; flush_req = '0;
        halt_req = 1'b0; step = 1'b0; resume = 1'b0; timeout_limit = '0;

        // reset: everything loads a bubble
        for (int i = 0; i < 2; i++) begin
            apply(1, 5'b00000, 5'b00000, 0, 0, 0, 0);
            check_val("rst_en", 64'(stage_en), 64'h1f);
            check_val("rst_bubble", 64'(stage_bubble), 64'h1f);
            tick();
        end
        apply(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        check_val("post_rst_halted", 64'(halted), 64'd0);
        check_val("post_rst_bubble", 64'(stage_bubble), 64'd0);
        check_val("post_rst_cyc", 64'(cycle_cnt), 64'd0);
        tick();

        // dcache stall held three cycles
        for (int i = 0; i < 3; i++) begin
            apply(0, 5'b01000, 5'b00000, 0, 0, 0, 0);
            check_val("stall_en", 64'(stage_en), 64'h10);
            check_val("stall_bubble", 64'(stage_bubble), 64'h10);
            tick();
        end
        apply(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        check_val("stall_cnt3", 64'(stall_cnt), PERF ? 64'd3 : 64'd0);
        tick();

        // flush above stall wins, flush below stall is held off
        apply(0, 5'b00001, 5'b00100, 0, 0, 0, 0);
        check_val("flush_en", 64'(stage_en), 64'h1f);
        check_val("flush_bubble", 64'(stage_bubble), 64'h06);
        tick();
        apply(0, 5'b01000, 5'b00100, 0, 0, 0, 0);
        check_val("held_flush_en", 64'(stage_en), 64'h10);
        tick();

        // halt, single step, resume
        apply(0, 5'b00000, 5'b00000, 1, 0, 0, 0);
        check_val("halt_t_en", 64'(stage_en), 64'h1f);
        check_val("halt_t_halted", 64'(halted), 64'd0);
        tick();
        apply(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        check_val("halt_t1_halted", 64'(halted), 64'd1);
        check_val("halt_t1_en", 64'(stage_en), 64'd0);
        tick();
        apply(0, 5'b00000, 5'b00000, 0, 1, 0, 0);
        check_val("step_req_en", 64'(stage_en), 64'd0);
        tick();
        apply(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        check_val("step_halted", 64'(halted), 64'd0);
        check_val("step_en", 64'(stage_en), 64'h1f);
        tick();
        apply(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        check_val("step_back_halted", 64'(halted), 64'd1);
        check_val("step_back_en", 64'(stage_en), 64'd0);
        tick();
        apply(0, 5'b00000, 5'b00000, 0, 1, 1, 0);
        tick();
        apply(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        check_val("resume_halted", 64'(halted), 64'd0);
        check_val("resume_en", 64'(stage_en), 64'h1f);
        tick();

        // watchdog with limit 4, then disabled
        apply(1, 5'b00000, 5'b00000, 0, 0, 0, 4);
        tick();
        for (int i = 0; i < 7; i++) begin
            apply(0, 5'b00001, 5'b00000, 0, 0, 0, 4);
            check_val("to_rise", 64'(timeout), 64'(i >= 5));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(0, 5'b00000, 5'b00000, 0, 0, 0, 4);
            check_val("to_sticky", 64'(timeout), 64'd1);
            tick();
        end
        apply(1, 5'b00000, 5'b00000, 0, 0, 0, 0);
        check_val("to_before_rst", 64'(timeout), 64'd1);
        tick();
        for (int i = 0; i < 12; i++) begin
            apply(0, 5'b00001, 5'b00000, 0, 0, 0, 0);
            tick();
        end
        apply(0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        check_val("to_disabled", 64'(timeout), 64'd0);
        tick();

        // randomized traffic against the model
        lim = 16'd3;
        for (int i = 0; i < 2000; i++) begin
            sr = ($urandom_range(0, 9) < 6) ? '0 : N'($urandom & $urandom);
            fr = ($urandom_range(0, 9) < 7) ? '0 : N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 49) == 0) lim = TO_W'($urandom_range(0, 6));
            apply($urandom_range(0, 99) < 2, sr, fr,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, lim);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
